// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and the E pipeline register layout used by the decode stage.
package y86_pkg;

  localparam int W = 64;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  typedef struct packed {
    logic [3:0]   icode;
    logic [3:0]   ifun;
    logic [2:0]   stat;
    logic [W-1:0] valC;
    logic [W-1:0] valA;
    logic [W-1:0] valB;
    logic [3:0]   dstE;
    logic [3:0]   dstM;
    logic [3:0]   srcA;
    logic [3:0]   srcB;
  } e_reg_t;

  localparam e_reg_t E_BUBBLE = '{
    icode: INOP, ifun: 4'h0, stat: SAOK,
    valC: {W{1'b0}}, valA: {W{1'b0}}, valB: {W{1'b0}},
    dstE: RNONE, dstM: RNONE, srcA: RNONE, srcB: RNONE
  };

  // A source of RNONE never forwards, even against a destination of RNONE.
  function automatic logic fwd_hit(input logic [3:0] src, input logic [3:0] dst);
    return (src != RNONE) && (src == dst);
  endfunction

endpackage

// File: rtl/y86_decode_stage_if.sv
// Decode-stage bus: D-register fields, register-file read port, forwarding sources, hazards and E register.
interface y86_decode_stage_if import y86_pkg::*; ();

  logic [3:0]   D_icode, D_ifun, D_rA, D_rB;
  logic [W-1:0] D_valC, D_valP;
  logic [2:0]   D_stat;
  logic [3:0]   srcA, srcB;
  logic [W-1:0] rvalA, rvalB;
  logic [3:0]   e_dstE;
  logic [W-1:0] e_valE;
  logic [3:0]   M_icode, M_dstE, M_dstM;
  logic [W-1:0] M_valE, m_valM;
  logic [3:0]   W_icode, W_dstE, W_dstM;
  logic [W-1:0] W_valE, W_valM;
  logic         e_mispredict;
  logic         stall_F, stall_D, bubble_D;
  logic [3:0]   E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [W-1:0] E_valC, E_valA, E_valB;
  logic [2:0]   E_stat;

  modport master (
    output D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, D_stat,
    output rvalA, rvalB, e_dstE, e_valE,
    output M_icode, M_dstE, M_dstM, M_valE, m_valM,
    output W_icode, W_dstE, W_dstM, W_valE, W_valM, e_mispredict,
    input  srcA, srcB, stall_F, stall_D, bubble_D,
    input  E_icode, E_ifun, E_valC, E_valA, E_valB,
    input  E_dstE, E_dstM, E_srcA, E_srcB, E_stat
  );

  modport slave (
    input  D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, D_stat,
    input  rvalA, rvalB, e_dstE, e_valE,
    input  M_icode, M_dstE, M_dstM, M_valE, m_valM,
    input  W_icode, W_dstE, W_dstM, W_valE, W_valM, e_mispredict,
    output srcA, srcB, stall_F, stall_D, bubble_D,
    output E_icode, E_ifun, E_valC, E_valA, E_valB,
    output E_dstE, E_dstM, E_srcA, E_srcB, E_stat
  );

endinterface

// File: rtl/y86_hazard_ctl.sv
// Combinational pipeline-control logic: load-use, ret and mispredict handling for F/D/E.
module y86_hazard_ctl import y86_pkg::*; (
  input  logic       rst_i,
  input  logic [3:0] D_icode_i,
  input  logic [3:0] E_icode_i,
  input  logic [3:0] E_dstM_i,
  input  logic [3:0] M_icode_i,
  input  logic [3:0] d_srcA_i,
  input  logic [3:0] d_srcB_i,
  input  logic       e_mispredict_i,
  output logic       stall_F_o,
  output logic       stall_D_o,
  output logic       bubble_D_o,
  output logic       bubble_E_o
);

  logic load_use;
  logic ret_pending;

  assign load_use = ((E_icode_i == IMRMOVQ) || (E_icode_i == IPOPQ)) &&
                    (E_dstM_i != RNONE) &&
                    ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));

  assign ret_pending = (D_icode_i == IRET) || (E_icode_i == IRET) || (M_icode_i == IRET);

  // Load-use wins over ret: the ret keeps its place in D until the load result can forward.
  always_comb begin
    stall_F_o  = 1'b0;
    stall_D_o  = 1'b0;
    bubble_D_o = 1'b0;
    bubble_E_o = 1'b0;
    if (rst_i) begin
      stall_F_o  = 1'b0;
      stall_D_o  = 1'b0;
      bubble_D_o = 1'b0;
      bubble_E_o = 1'b0;
    end else begin
      stall_F_o  = load_use | ret_pending;
      stall_D_o  = load_use;
      bubble_D_o = e_mispredict_i | (ret_pending & ~load_use);
      bubble_E_o = e_mispredict_i | load_use;
    end
  end

endmodule

// File: rtl/y86_decode_stage.sv
// Y86-64 decode stage: register tags, operand forwarding from E/M/W, and the D-to-E pipeline register.
module y86_decode_stage import y86_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  y86_decode_stage_if.slave dif
);

  logic [3:0]   d_srcA, d_srcB, d_dstE, d_dstM;
  logic [W-1:0] d_valA, d_valB;
  logic         bubble_E;
  e_reg_t       e_d, e_q;

  // Register tag selection per instruction class.
  always_comb begin
    d_srcA = RNONE;
    d_srcB = RNONE;
    d_dstE = RNONE;
    d_dstM = RNONE;
    case (dif.D_icode)
      IRRMOVQ: begin d_srcA = dif.D_rA; d_dstE = dif.D_rB; end
      IIRMOVQ: begin d_dstE = dif.D_rB; end
      IRMMOVQ: begin d_srcA = dif.D_rA; d_srcB = dif.D_rB; end
      IMRMOVQ: begin d_srcB = dif.D_rB; d_dstM = dif.D_rA; end
      IOPQ:    begin d_srcA = dif.D_rA; d_srcB = dif.D_rB; d_dstE = dif.D_rB; end
      ICALL:   begin d_srcB = RRSP; d_dstE = RRSP; end
      IRET:    begin d_srcA = RRSP; d_srcB = RRSP; d_dstE = RRSP; end
      IPUSHQ:  begin d_srcA = dif.D_rA; d_srcB = RRSP; d_dstE = RRSP; end
      IPOPQ:   begin d_srcA = RRSP; d_srcB = RRSP; d_dstE = RRSP; d_dstM = dif.D_rA; end
      default: begin d_srcA = RNONE; d_srcB = RNONE; d_dstE = RNONE; d_dstM = RNONE; end
    endcase
  end

  assign dif.srcA = d_srcA;
  assign dif.srcB = d_srcB;

  // Operand A: valP for jXX/call, else youngest matching producer, else register file.
  always_comb begin
    d_valA = dif.rvalA;
    if ((dif.D_icode == IJXX) || (dif.D_icode == ICALL)) begin
      d_valA = dif.D_valP;
    end else if (fwd_hit(d_srcA, dif.e_dstE)) begin
      d_valA = dif.e_valE;
    end else if (fwd_hit(d_srcA, dif.M_dstM)) begin
      d_valA = dif.m_valM;
    end else if (fwd_hit(d_srcA, dif.M_dstE)) begin
      d_valA = dif.M_valE;
    end else if (fwd_hit(d_srcA, dif.W_dstM)) begin
      d_valA = dif.W_valM;
    end else if (fwd_hit(d_srcA, dif.W_dstE)) begin
      d_valA = dif.W_valE;
    end else begin
      d_valA = dif.rvalA;
    end
  end

  // Operand B: same priority chain as A without the valP term.
  always_comb begin
    d_valB = dif.rvalB;
    if (fwd_hit(d_srcB, dif.e_dstE)) begin
      d_valB = dif.e_valE;
    end else if (fwd_hit(d_srcB, dif.M_dstM)) begin
      d_valB = dif.m_valM;
    end else if (fwd_hit(d_srcB, dif.M_dstE)) begin
      d_valB = dif.M_valE;
    end else if (fwd_hit(d_srcB, dif.W_dstM)) begin
      d_valB = dif.W_valM;
    end else if (fwd_hit(d_srcB, dif.W_dstE)) begin
      d_valB = dif.W_valE;
    end else begin
      d_valB = dif.rvalB;
    end
  end

  y86_hazard_ctl u_hazard (
    .rst_i          (rst),
    .D_icode_i      (dif.D_icode),
    .E_icode_i      (e_q.icode),
    .E_dstM_i       (e_q.dstM),
    .M_icode_i      (dif.M_icode),
    .d_srcA_i       (d_srcA),
    .d_srcB_i       (d_srcB),
    .e_mispredict_i (dif.e_mispredict),
    .stall_F_o      (dif.stall_F),
    .stall_D_o      (dif.stall_D),
    .bubble_D_o     (dif.bubble_D),
    .bubble_E_o     (bubble_E)
  );

  // Next E register contents: a bubble or the freshly decoded instruction.
  always_comb begin
    e_d = E_BUBBLE;
    if (bubble_E) begin
      e_d = E_BUBBLE;
    end else begin
      e_d.icode = dif.D_icode;
      e_d.ifun  = dif.D_ifun;
      e_d.stat  = dif.D_stat;
      e_d.valC  = dif.D_valC;
      e_d.valA  = d_valA;
      e_d.valB  = d_valB;
      e_d.dstE  = d_dstE;
      e_d.dstM  = d_dstM;
      e_d.srcA  = d_srcA;
      e_d.srcB  = d_srcB;
    end
  end

  // D-to-E pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q <= E_BUBBLE;
    end else begin
      e_q <= e_d;
    end
  end

  assign dif.E_icode = e_q.icode;
  assign dif.E_ifun  = e_q.ifun;
  assign dif.E_stat  = e_q.stat;
  assign dif.E_valC  = e_q.valC;
  assign dif.E_valA  = e_q.valA;
  assign dif.E_valB  = e_q.valB;
  assign dif.E_dstE  = e_q.dstE;
  assign dif.E_dstM  = e_q.dstM;
  assign dif.E_srcA  = e_q.srcA;
  assign dif.E_srcB  = e_q.srcB;

endmodule
